mem_req_arbiter: RTL and testbench
==================================

Name: mem_req_arbiter

Overview:
Shares the single SRAM-like memory port between the instruction-fetch requester (port I) and the EX-stage load/store requester (port D).
- Arbitrates the address phase with data priority and an anti-starvation override.
- Locks a granted request until it is accepted downstream.
- Tracks outstanding transactions in an in-order owner FIFO and steers each data_ok/rdata back to its owner.
- Supports discarding in-flight fetch responses on pipeline flush.

Parameters:
DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, >=2)
STARVE_LIMIT, 8, consecutive cycles port I may wait with inst_req high before it wins priority

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_req  in  1  fetch request valid; held until inst_addr_ok
inst_wr  in  1  write flag (0 for fetch)
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  request address
inst_wstrb  in  4  byte write strobes
inst_wdata  in  32  write data
inst_addr_ok  out  1  fetch request accepted this cycle
inst_data_ok  out  1  fetch response valid this cycle
inst_rdata  out  32  response data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  same meaning, port D
data_addr_ok, data_data_ok  out  1  same meaning, port D
data_rdata  out  32  response data
inst_cancel  in  1  flush pulse: discard all outstanding and locked-pending port-I responses
mem_req  out  1  downstream request valid
mem_wr, mem_size, mem_addr, mem_wstrb, mem_wdata  out  1/2/32/4/32  muxed request fields
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid, in request order
mem_rdata  in  32  downstream response data

Behaviour:
- Reset (reset high at a clk edge): FIFO count and both pointers cleared, lock cleared, starve counter 0, discard_pending 0.
- All outputs are combinational. While reset is high, mem_req, both addr_ok and both data_ok are forced to 0.
- State machine, 2 states:
  - IDLE: no locked grant.
  - LOCKED(owner): mem_req was high last cycle without mem_addr_ok.
  - IDLE -> LOCKED when mem_req & ~mem_addr_ok.
  - LOCKED -> IDLE on mem_addr_ok.
- Grant in IDLE:
  - If only one port requests, grant it.
  - If both request, grant D, unless starve_cnt == STARVE_LIMIT, then grant I.
- Grant in LOCKED: the locked owner, even if the other port also requests.
- mem_req = granted port's req & ~full. full = (count == DEPTH). All mem_* request fields are muxed from the granted port.
- Acceptance = mem_req & mem_addr_ok. The granted port's addr_ok = acceptance, with zero latency.
- On acceptance, push {owner, discard} into the FIFO. discard = 1 only if the owner is I and (discard_pending or inst_cancel in the same cycle).
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) each cycle inst_req is high and I is not accepted.
  - Clears to 0 on I acceptance or when inst_req is low.
- Responses: mem_data_ok with count>0 pops the head entry.
  - Owner D: data_data_ok=1.
  - Owner I with discard=0: inst_data_ok=1.
  - Owner I with discard=1: no data_ok to either port.
  - mem_rdata is driven to both rdata outputs.
- mem_data_ok with count==0: ignored, count stays 0, no data_ok.
- Push and pop in the same cycle: count unchanged, both pointers advance. full is evaluated from the registered count only, so no push occurs at count==DEPTH even if a pop happens that cycle.
- Pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits wide.
- inst_cancel:
  - Sets discard=1 on every valid FIFO entry whose owner is I.
  - If LOCKED(owner=I), sets discard_pending. discard_pending clears when that request is accepted.
  - The locked request is never withdrawn: cancel has no effect on lock, grant or addr_ok.
  - A cancel arriving in the same cycle as a pop of an I entry suppresses that entry's inst_data_ok.
- Reset mid-transaction: all tracking is lost. Downstream is reset together with this block.

Decomposition:
- Shared package: size encodings (BYTE/HALF/WORD), owner ID constants (OWN_I=0, OWN_D=1), state encodings IDLE/LOCKED.
- One sub-module, owner_fifo:
  - DEPTH entries of {owner, discard}, push/pop, count/full/empty.
  - A bulk "mark owner-I discard" input.

Test Plan:
- Both ports request at 0x1c000000 (I) and 0x00001000 (D), mem_addr_ok=1 -> D accepted first, I next cycle; data_ok returns to D then I with rdata 0xAAAA0001 then 0xAAAA0002.
- D requests continuously, I requests, STARVE_LIMIT=8 -> I accepted no later than 9 cycles after inst_req rises; starve_cnt back to 0.
- D granted with mem_addr_ok=0 for 3 cycles while I also requests -> mem_addr stays D's address, D accepted on cycle 4, then I.
- Four requests accepted, no data_ok, DEPTH=4 -> mem_req=0 and addr_ok=0 while both ports request; one mem_data_ok -> the next request is accepted the following cycle.
- Two I fetches outstanding, inst_cancel pulse -> next two mem_data_ok produce no inst_data_ok; a new fetch after cancel returns inst_data_ok=1.
- mem_data_ok with an empty FIFO -> no data_ok on either port, count stays 0. Reset asserted with count=3 -> count=0 and outputs idle next cycle.

Source files
------------

// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
//   - size encodings used on the *_size request fields
//   - owner IDs stored in the outstanding-transaction FIFO
//   - address-phase lock states
//   - FIFO entry layout {owner, discard}
package mem_req_arbiter_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } size_e;

    localparam logic OWN_I = 1'b0;  // instruction-fetch port
    localparam logic OWN_D = 1'b1;  // load/store port

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    typedef struct packed {
        logic owner;
        logic discard;
    } fifo_entry_t;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order FIFO of outstanding transaction owners.
// Each entry records which port issued the request and whether its response
// must be swallowed. A bulk mark input sets discard on every live port-I entry.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   push_i           write push_entry_i at the tail (caller guarantees ~full_o)
//   push_entry_i     {owner, discard} of the accepted request
//   pop_i            drop the head entry (caller guarantees count_o != 0)
//   mark_discard_i   set discard on all live entries owned by port I
//   head_o           entry at the head
//   count_o          live entries, 0..DEPTH
//   full_o           count_o == DEPTH
module mem_req_arbiter_owner_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  fifo_entry_t              push_entry_i,
    input  logic                     pop_i,
    input  logic                     mark_discard_i,
    output fifo_entry_t              head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    entry_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic [DEPTH-1:0] valid;

    // An entry is live when its distance from the read pointer (mod DEPTH)
    // is below the occupancy count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
        logic [AW-1:0] offs;
        assign offs      = AW'(gi) - rd_ptr_q;
        assign valid[gi] = {1'b0, offs} < count_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_i);
        rd_ptr_d = rd_ptr_q + AW'(pop_i);
        count_d  = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: only pointers/count define which entries are live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && wr_ptr_q == AW'(i)) begin
                entry_q[i] <= push_entry_i;
            end else if (mark_discard_i && valid[i] && entry_q[i].owner == OWN_I) begin
                entry_q[i].discard <= 1'b1;
            end
        end
    end

    assign head_o  = entry_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));

endmodule

// File: rtl/mem_req_arbiter.sv
// Two-port (fetch I / load-store D) arbiter onto one SRAM-like memory port.
// Data port has priority unless fetch has waited STARVE_LIMIT cycles. A
// granted-but-unaccepted request is locked until mem_addr_ok. Accepted
// requests are tracked in order so responses return to their owner; fetch
// responses can be discarded by inst_cancel.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   inst_* / data_*                  requester ports (req, wr, size, addr, wstrb,
//                                    wdata in; addr_ok, data_ok, rdata out)
//   inst_cancel                      flush pulse for outstanding fetch responses
//   mem_req/wr/size/addr/wstrb/wdata downstream request
//   mem_addr_ok, mem_data_ok,
//   mem_rdata                        downstream handshake and response
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        inst_cancel,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e        state_q;
    logic          lock_owner_q;
    logic [SW-1:0] starve_q;
    logic          discard_pending_q;

    logic          grant_owner;
    logic          gnt_req;
    logic          accept;
    logic          accept_i;
    logic          pop;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    fifo_entry_t   push_entry;
    fifo_entry_t   head;

    always_comb begin
        grant_owner = OWN_D;
        if (state_q == LOCKED) begin
            grant_owner = lock_owner_q;
        end else if (inst_req && !data_req) begin
            grant_owner = OWN_I;
        end else if (inst_req && data_req && starve_q == SW'(STARVE_LIMIT)) begin
            grant_owner = OWN_I;
        end
    end

    assign gnt_req   = (grant_owner == OWN_I) ? inst_req : data_req;
    assign mem_req   = gnt_req & ~fifo_full & ~reset;
    assign mem_wr    = (grant_owner == OWN_I) ? inst_wr    : data_wr;
    assign mem_size  = (grant_owner == OWN_I) ? inst_size  : data_size;
    assign mem_addr  = (grant_owner == OWN_I) ? inst_addr  : data_addr;
    assign mem_wstrb = (grant_owner == OWN_I) ? inst_wstrb : data_wstrb;
    assign mem_wdata = (grant_owner == OWN_I) ? inst_wdata : data_wdata;

    assign accept       = mem_req & mem_addr_ok;
    assign accept_i     = accept & (grant_owner == OWN_I);
    assign inst_addr_ok = accept_i;
    assign data_addr_ok = accept & (grant_owner == OWN_D);

    // A fetch accepted while a cancel is pending (or arriving now) is dead on arrival.
    assign push_entry.owner   = grant_owner;
    assign push_entry.discard = (grant_owner == OWN_I) & (discard_pending_q | inst_cancel);

    assign pop = mem_data_ok & (fifo_count != '0) & ~reset;

    // inst_cancel is checked here too so a cancel coinciding with the pop still
    // suppresses the head fetch response (the FIFO mark lands one cycle later).
    assign data_data_ok = pop & (head.owner == OWN_D);
    assign inst_data_ok = pop & (head.owner == OWN_I) & ~head.discard & ~inst_cancel;
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= IDLE;
            lock_owner_q      <= OWN_I;
            starve_q          <= '0;
            discard_pending_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state_q      <= LOCKED;
                        lock_owner_q <= grant_owner;
                    end
                end
                LOCKED: begin
                    if (accept) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (inst_req && !accept_i) begin
                if (starve_q != SW'(STARVE_LIMIT)) begin
                    starve_q <= starve_q + 1'b1;
                end
            end else begin
                starve_q <= '0;
            end

            if (accept_i) begin
                discard_pending_q <= 1'b0;
            end else if (inst_cancel && state_q == LOCKED && lock_owner_q == OWN_I) begin
                discard_pending_q <= 1'b1;
            end
        end
    end

    mem_req_arbiter_owner_fifo #(
        .DEPTH(DEPTH)
    ) u_owner_fifo (
        .clk            (clk),
        .reset          (reset),
        .push_i         (accept),
        .push_entry_i   (push_entry),
        .pop_i          (pop),
        .mark_discard_i (inst_cancel),
        .head_o         (head),
        .count_o        (fifo_count),
        .full_o         (fifo_full)
    );

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata;
    logic [3:0]  inst_wstrb;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        inst_cancel;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;
    int hit;

    always #5 clk = ~clk;

    mem_req_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .inst_cancel(inst_cancel),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed there.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling.
    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = '0; inst_wstrb = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        inst_cancel = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        cyc();
        // Outputs forced idle while reset is high, even with live stimulus.
        data_req = 1; inst_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
        settle();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_addr_ok", {inst_addr_ok, data_addr_ok}, 0);
        chk("rst_data_ok", {inst_data_ok, data_data_ok}, 0);
        cyc();
        reset = 0;
        idle_inputs();

        // ---- Priority: D first, then I; responses in order ----
        inst_req = 1; inst_addr = 32'h1c000000;
        data_req = 1; data_addr = 32'h00001000; data_wr = 1; data_wstrb = 4'hf; data_wdata = 32'h12345678;
        mem_addr_ok = 1;
        settle();
        chk("pri_addr_d", mem_addr, 32'h00001000);
        chk("pri_wdata_d", mem_wdata, 32'h12345678);
        chk("pri_ok_d", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc();
        data_req = 0; data_wr = 0;
        settle();
        chk("pri_addr_i", mem_addr, 32'h1c000000);
        chk("pri_ok_i", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc();
        inst_req = 0; mem_addr_ok = 0;
        mem_data_ok = 1; mem_rdata = 32'hAAAA0001;
        settle();
        chk("rsp1_ok", {inst_data_ok, data_data_ok}, 2'b01);
        chk("rsp1_rdata", data_rdata, 32'hAAAA0001);
        cyc();
        mem_rdata = 32'hAAAA0002;
        settle();
        chk("rsp2_ok", {inst_data_ok, data_data_ok}, 2'b10);
        chk("rsp2_rdata", inst_rdata, 32'hAAAA0002);
        cyc();
        mem_data_ok = 0;

        // ---- Starvation: I wins after exactly 8 waiting cycles ----
        data_req = 1; data_addr = 32'h00002000;
        inst_req = 1; inst_addr = 32'h1c000040;
        mem_addr_ok = 1; mem_data_ok = 1;
        hit = -1;
        for (int k = 0; k < 12; k++) begin
            settle();
            if (inst_addr_ok) begin
                hit = k;
                break;
            end
            @(posedge clk);
        end
        chk("starve_hit_cycle", hit, 8);
        cyc();
        settle();
        // Counter cleared on I acceptance, so D regains priority.
        chk("starve_cleared", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc();
        data_req = 0; inst_req = 0; mem_addr_ok = 0;
        cyc();
        mem_data_ok = 0;

        // ---- Lock: D held with mem_addr_ok low for 3 cycles ----
        data_req = 1; data_addr = 32'h00003000;
        inst_req = 1; inst_addr = 32'h1c000080;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("lock_d_addr%0d", k), {mem_req, data_addr_ok, mem_addr}, {2'b10, 32'h00003000});
            cyc();
        end
        mem_addr_ok = 1;
        settle();
        chk("lock_d_accept", {inst_addr_ok, data_addr_ok}, 2'b01);
        cyc();
        data_req = 0;
        settle();
        chk("lock_then_i", {inst_addr_ok, mem_addr}, {1'b1, 32'h1c000080});
        cyc();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("lock_rsp_d", {inst_data_ok, data_data_ok}, 2'b01);
        cyc();
        settle();
        chk("lock_rsp_i", {inst_data_ok, data_data_ok}, 2'b10);
        cyc();
        mem_data_ok = 0;

        // ---- Full FIFO blocks requests; one pop frees a slot ----
        data_req = 1; data_addr = 32'h00004000;
        inst_req = 1; inst_addr = 32'h1c0000c0;
        mem_addr_ok = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("fill_%0d", k), data_addr_ok, 1);
            cyc();
        end
        settle();
        chk("full_mem_req", mem_req, 0);
        chk("full_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        mem_data_ok = 1;
        settle();
        // Full is judged on the registered count, so a same-cycle pop does not open a slot.
        chk("full_pop_same_cycle", {mem_req, data_data_ok}, 2'b01);
        cyc();
        mem_data_ok = 0;
        settle();
        chk("full_after_pop", {mem_req, data_addr_ok}, 2'b11);
        cyc();
        data_req = 0; inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("full_drain_%0d", k), {inst_data_ok, data_data_ok}, 2'b01);
            cyc();
        end
        mem_data_ok = 0;

        // ---- Cancel: two outstanding fetches are discarded ----
        inst_req = 1; inst_addr = 32'h1c000100; mem_addr_ok = 1;
        cyc();
        cyc();
        inst_req = 0; mem_addr_ok = 0; inst_cancel = 1;
        cyc();
        inst_cancel = 0; mem_data_ok = 1;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk($sformatf("cancel_drop_%0d", k), {inst_data_ok, data_data_ok}, 2'b00);
            cyc();
        end
        mem_data_ok = 0;
        inst_req = 1; mem_addr_ok = 1;
        settle();
        chk("post_cancel_fetch", inst_addr_ok, 1);
        cyc();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hBBBB0003;
        settle();
        chk("post_cancel_rsp", {inst_data_ok, inst_rdata}, {1'b1, 32'hBBBB0003});
        cyc();
        mem_data_ok = 0;

        // ---- Cancel coinciding with the pop of a fetch ----
        inst_req = 1; mem_addr_ok = 1;
        cyc();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; inst_cancel = 1;
        settle();
        chk("cancel_same_pop", inst_data_ok, 0);
        cyc();
        mem_data_ok = 0; inst_cancel = 0;

        // ---- Cancel while a fetch is locked: still issued, response dropped ----
        inst_req = 1; inst_addr = 32'h1c000200;
        cyc();
        inst_cancel = 1; data_req = 1; data_addr = 32'h00005000;
        settle();
        chk("pend_grant_kept", {mem_req, inst_addr_ok, mem_addr}, {2'b10, 32'h1c000200});
        cyc();
        inst_cancel = 0; mem_addr_ok = 1;
        settle();
        chk("pend_accept_i", {inst_addr_ok, data_addr_ok}, 2'b10);
        cyc();
        inst_req = 0;
        settle();
        chk("pend_accept_d", data_addr_ok, 1);
        cyc();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("pend_rsp_dropped", {inst_data_ok, data_data_ok}, 2'b00);
        cyc();
        settle();
        chk("pend_rsp_d", {inst_data_ok, data_data_ok}, 2'b01);
        cyc();

        // ---- Spurious mem_data_ok on an empty FIFO ----
        settle();
        chk("empty_no_ok", {inst_data_ok, data_data_ok}, 2'b00);
        cyc();
        mem_data_ok = 0; data_req = 1; data_addr = 32'h00006000; mem_addr_ok = 1;
        cyc();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        settle();
        chk("empty_then_one", data_data_ok, 1);
        cyc();
        settle();
        chk("empty_stays_zero", {inst_data_ok, data_data_ok}, 2'b00);
        cyc();
        mem_data_ok = 0;

        // ---- Reset with three outstanding ----
        data_req = 1; mem_addr_ok = 1;
        cyc();
        cyc();
        cyc();
        reset = 1; mem_data_ok = 1;
        settle();
        chk("midrst_outputs", {mem_req, data_addr_ok, data_data_ok, inst_data_ok}, 4'b0000);
        cyc();
        reset = 0; data_req = 0; mem_addr_ok = 0;
        settle();
        chk("midrst_count_zero", {inst_data_ok, data_data_ok, mem_req}, 3'b000);
        cyc();
        mem_data_ok = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
